// File: rtl/stack_port_arbiter.sv
// stack_port_arbiter
// Shares a single stack32 port among NREQ requesters (control FSM, local-variable
// frame unit, constant loader) with round-robin arbitration. Only one stack
// transaction is in flight at a time; the granted requester gets a one-cycle ack
// together with pop data.
//
// Optional feature: define ARB_OCCUPANCY_EN to track stack occupancy and reject
// pops from an empty stack or pushes to a full one without touching the stack.
//
// Ports
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   req           per-requester request level, held until its ack
//   req_push      per-requester op (1=push, 0=pop), stable while req is high
//   req_wdata     push data, slice i belongs to requester i
//   ack           one-cycle one-hot completion pulse
//   rdata         pop result, valid in the ack cycle and held until the next ack
//   err           rejected-op flag, valid in the ack cycle
//   busy          high whenever a transaction is being handled
//   grant_id      index of the current/last granted requester
//   depth         stack occupancy (tied to 0 without ARB_OCCUPANCY_EN)
//   stk_push, stk_trigger, stk_wdata   to the stack32 port
//   stk_rdata, stk_done                from the stack32 port
module stack_port_arbiter #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 32,
  parameter int DEPTH = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req,
  input  logic [NREQ-1:0]               req_push,
  input  logic [NREQ*WIDTH-1:0]         req_wdata,
  output logic [NREQ-1:0]               ack,
  output logic [WIDTH-1:0]              rdata,
  output logic                          err,
  output logic                          busy,
  output logic [1:0]                    grant_id,
  output logic [$clog2(DEPTH+1)-1:0]    depth,
  output logic                          stk_push,
  output logic                          stk_trigger,
  output logic [WIDTH-1:0]              stk_wdata,
  input  logic [WIDTH-1:0]              stk_rdata,
  input  logic                          stk_done
);

  localparam int DW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [3:0]       req_pad;
  logic [3:0]       push_pad;
  logic [2:0]       cand;
  logic             found;
  logic [1:0]       next_gnt;
  logic             sel_push;
  logic [WIDTH-1:0] sel_wdata;
  logic             reject;

  // Round-robin pick: scan from the requester after the last grant, wrapping
  // around, so the last winner has the lowest priority. The request vectors are
  // padded to four bits so a two-bit index is always in range.
  always_comb begin
    req_pad              = '0;
    push_pad             = '0;
    req_pad[NREQ-1:0]    = req;
    push_pad[NREQ-1:0]   = req_push;
    found                = 1'b0;
    next_gnt             = grant_id;
    cand                 = '0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = {1'b0, grant_id} + 3'(off);
      if (cand >= 3'(NREQ)) cand = cand - 3'(NREQ);
      if (!found && req_pad[cand[1:0]]) begin
        found    = 1'b1;
        next_gnt = cand[1:0];
      end
    end
    sel_push  = push_pad[next_gnt];
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (next_gnt == 2'(i)) sel_wdata = req_wdata[i*WIDTH +: WIDTH];
    end
  end

`ifdef ARB_OCCUPANCY_EN
  // An op that would underflow or overflow the stack never reaches it.
  assign reject = sel_push ? (depth == DW'(DEPTH)) : (depth == '0);
`else
  assign reject = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Rejected ops skip the stack entirely and go straight to the ack cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found) state_next = reject ? DONE : ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (stk_done) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != IDLE);
    stk_trigger = (state == ISSUE);
    ack         = '0;
    for (int i = 0; i < NREQ; i++) begin
      ack[i] = (state == DONE) && (grant_id == 2'(i));
    end
  end

  // grant_id resets to the last requester so requester 0 wins the first grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_id  <= 2'(NREQ-1);
      stk_push  <= 1'b0;
      stk_wdata <= '0;
      rdata     <= '0;
    end else begin
      if (state == IDLE && found) begin
        grant_id  <= next_gnt;
        stk_push  <= sel_push;
        stk_wdata <= sel_wdata;
        if (reject) rdata <= '0;
      end
      if (state == WAIT && stk_done && !stk_push) rdata <= stk_rdata;
    end
  end

`ifdef ARB_OCCUPANCY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (state == IDLE && found) begin
      err <= reject;
    end
  end

  // Occupancy changes once the op has completed, and never for a rejected op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth <= '0;
    end else if (state == DONE && !err) begin
      depth <= stk_push ? depth + 1'b1 : depth - 1'b1;
    end
  end
`else
  assign err   = 1'b0;
  assign depth = '0;
`endif

endmodule

// File: tb/tb_stack_port_arbiter.sv
// tb_stack_port_arbiter
// Drives stack_port_arbiter (NREQ=3) against a behavioural stack32 responder and
// checks grants, acks, pop data and error flags against a queue-based reference
// model of round-robin arbitration over a LIFO stack.
module tb_stack_port_arbiter;

  localparam int NREQ  = 3;
  localparam int WIDTH = 32;
  localparam int DEPTH = 256;
  localparam int DW    = $clog2(DEPTH+1);

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        req_push;
  logic [NREQ*WIDTH-1:0]  req_wdata;
  logic [NREQ-1:0]        ack;
  logic [WIDTH-1:0]       rdata;
  logic                   err;
  logic                   busy;
  logic [1:0]             grant_id;
  logic [DW-1:0]          depth;
  logic                   stk_push;
  logic                   stk_trigger;
  logic [WIDTH-1:0]       stk_wdata;
  logic [WIDTH-1:0]       stk_rdata;
  logic                   stk_done;

  stack_port_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req(req), .req_push(req_push), .req_wdata(req_wdata),
    .ack(ack), .rdata(rdata), .err(err), .busy(busy), .grant_id(grant_id),
    .depth(depth), .stk_push(stk_push), .stk_trigger(stk_trigger),
    .stk_wdata(stk_wdata), .stk_rdata(stk_rdata), .stk_done(stk_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Behavioural stack32: done arrives a configurable number of cycles after trigger.
  logic [WIDTH-1:0] resp_stack[$];
  int               trig_count = 0;
  int               stk_lat = 2;
  bit               rand_lat = 0;
  int               r_lat;
  logic [WIDTH-1:0] r_val;

  // Reference model: expected stack contents, last winner and held pop data.
  logic [WIDTH-1:0] model_stack[$];
  int               model_last = NREQ-1;
  logic [WIDTH-1:0] model_rdata = '0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int id, input bit push, input logic [WIDTH-1:0] data);
    req[id]                     = 1'b1;
    req_push[id]                = push;
    req_wdata[id*WIDTH +: WIDTH] = data;
  endtask

  function automatic int pickNext(input logic [NREQ-1:0] pend);
    for (int k = 1; k <= NREQ; k++) begin
      int c = (model_last + k) % NREQ;
      if (pend[c]) return c;
    end
    return -1;
  endfunction

  initial begin
    stk_done  = 1'b0;
    stk_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (stk_trigger === 1'b1) begin
        trig_count++;
        r_val = '0;
        if (stk_push) resp_stack.push_back(stk_wdata);
        else if (resp_stack.size() > 0) r_val = resp_stack.pop_back();
        r_lat = rand_lat ? int'($urandom_range(1, 4)) : stk_lat;
        repeat (r_lat) @(posedge clk);
        #1;
        stk_done  = 1'b1;
        stk_rdata = r_val;
        @(posedge clk); #1;
        stk_done  = 1'b0;
        stk_rdata = $urandom;
      end
    end
  end

  task automatic resetDut();
    rst       = 1'b1;
    req       = '0;
    req_push  = '0;
    req_wdata = '0;
    repeat (8) @(posedge clk);
    #1;
    resp_stack.delete();
    model_stack.delete();
    model_last  = NREQ-1;
    model_rdata = '0;
    rst = 1'b0;
  endtask

  // Raises the requests in mask together and follows them until ntx acks.
  // With hold set, each requester re-requests right after its ack.
  task automatic runBatch(input logic [NREQ-1:0] mask, input logic [NREQ-1:0] ops,
                          input int ntx, input bit hold, input string tag,
                          input logic [NREQ*WIDTH-1:0] init_data);
    logic [NREQ-1:0]  pend;
    logic [NREQ-1:0]  exp_ack;
    logic [WIDTH-1:0] d[NREQ];
    int               done;
    int               cyc;
    int               w;
    bit               rej;
    logic             prev_trig;
    pend      = mask;
    done      = 0;
    cyc       = 0;
    prev_trig = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      d[i] = init_data[i*WIDTH +: WIDTH];
      if (mask[i]) applyStimulus(i, ops[i], d[i]);
    end
    while (done < ntx && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      w = pickNext(pend);
      if (stk_trigger === 1'b1 && w >= 0) begin
        checkOutput({tag, "_pulse"}, 64'(prev_trig), 64'(0));
        checkOutput({tag, "_grant"}, 64'(grant_id), 64'(w));
        checkOutput({tag, "_op"}, 64'(stk_push), 64'(ops[w]));
        if (ops[w]) checkOutput({tag, "_wdata"}, 64'(stk_wdata), 64'(d[w]));
      end
      prev_trig = stk_trigger;
      if (ack !== '0 && w >= 0) begin
        exp_ack    = '0;
        exp_ack[w] = 1'b1;
        checkOutput({tag, "_ack"}, 64'(ack), 64'(exp_ack));
        rej = 1'b0;
`ifdef ARB_OCCUPANCY_EN
        rej = ops[w] ? (model_stack.size() == DEPTH) : (model_stack.size() == 0);
`endif
        if (rej) model_rdata = '0;
        else if (ops[w]) model_stack.push_back(d[w]);
        else model_rdata = model_stack.pop_back();
        checkOutput({tag, "_rdata"}, 64'(rdata), 64'(model_rdata));
        checkOutput({tag, "_err"}, 64'(err), 64'(rej));
        model_last = w;
        done++;
        if (hold) begin
          d[w] = $urandom;
          applyStimulus(w, ops[w], d[w]);
        end else begin
          req[w]  = 1'b0;
          pend[w] = 1'b0;
        end
      end
    end
    req = '0;
    if (done < ntx) checkOutput({tag, "_timeout"}, 64'(done), 64'(ntx));
    @(posedge clk); #1;
`ifdef ARB_OCCUPANCY_EN
    checkOutput({tag, "_depth"}, 64'(depth), 64'(model_stack.size()));
`else
    checkOutput({tag, "_depth"}, 64'(depth), 64'(0));
`endif
  endtask

  initial begin
    int t0;
    logic [NREQ-1:0] mask;
    logic [NREQ-1:0] ops;
    int avail;

    resetDut();
    checkOutput("rst_ack", 64'(ack), 64'(0));
    checkOutput("rst_rdata", 64'(rdata), 64'(0));
    checkOutput("rst_err", 64'(err), 64'(0));
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_grant", 64'(grant_id), 64'(NREQ-1));
    checkOutput("rst_stk_push", 64'(stk_push), 64'(0));
    checkOutput("rst_trigger", 64'(stk_trigger), 64'(0));
    checkOutput("rst_wdata", 64'(stk_wdata), 64'(0));
    checkOutput("rst_depth", 64'(depth), 64'(0));

    // Push from requester 0 with done two cycles after trigger: ack in cycle 4.
    stk_lat = 2;
    t0 = trig_count;
    applyStimulus(0, 1'b1, 32'h0000002A);
    @(posedge clk); #1;
    checkOutput("push_c1_trigger", 64'(stk_trigger), 64'(1));
    checkOutput("push_c1_op", 64'(stk_push), 64'(1));
    checkOutput("push_c1_wdata", 64'(stk_wdata), 64'h2A);
    checkOutput("push_c1_busy", 64'(busy), 64'(1));
    checkOutput("push_c1_grant", 64'(grant_id), 64'(0));
    @(posedge clk); #1;
    checkOutput("push_c2_trigger", 64'(stk_trigger), 64'(0));
    checkOutput("push_c2_wdata", 64'(stk_wdata), 64'h2A);
    checkOutput("push_c2_ack", 64'(ack), 64'(0));
    @(posedge clk); #1;
    checkOutput("push_c3_ack", 64'(ack), 64'(0));
    @(posedge clk); #1;
    checkOutput("push_c4_ack", 64'(ack), 64'b001);
    checkOutput("push_c4_err", 64'(err), 64'(0));
    req[0] = 1'b0;
    model_stack.push_back(32'h2A);
    model_last = 0;
    @(posedge clk); #1;
    checkOutput("push_c5_busy", 64'(busy), 64'(0));
    checkOutput("push_triggers", 64'(trig_count - t0), 64'(1));

    // Push 0x11 then pop it back from requester 1.
    runBatch(3'b010, 3'b010, 1, 1'b0, "push11", {32'h0, 32'h11, 32'h0});
    runBatch(3'b010, 3'b000, 1, 1'b0, "pop11", '0);
    checkOutput("pop11_held", 64'(rdata), 64'h11);

    // Two requesters rising together are served 0 then 1.
    t0 = trig_count;
    runBatch(3'b011, 3'b011, 2, 1'b0, "contend", {$urandom, $urandom, $urandom});
    checkOutput("contend_triggers", 64'(trig_count - t0), 64'(2));

    // All requesters held for six transactions: 0,1,2,0,1,2 after reset.
    resetDut();
    runBatch(3'b111, 3'b111, 6, 1'b1, "fair", {$urandom, $urandom, $urandom});

    // Reset while waiting on the stack aborts silently; next grant restarts at 0.
    stk_lat = 5;
    applyStimulus(0, 1'b1, 32'hDEAD);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("rstw_busy_before", 64'(busy), 64'(1));
    rst = 1'b1;
    #1;
    checkOutput("rstw_busy", 64'(busy), 64'(0));
    checkOutput("rstw_ack", 64'(ack), 64'(0));
    checkOutput("rstw_trigger", 64'(stk_trigger), 64'(0));
    resetDut();
    stk_lat = 2;
    runBatch(3'b011, 3'b011, 2, 1'b0, "after_rst", {$urandom, $urandom, $urandom});

`ifdef ARB_OCCUPANCY_EN
    // Pop from an empty stack is rejected without touching the stack.
    resetDut();
    t0 = trig_count;
    runBatch(3'b001, 3'b000, 1, 1'b0, "empty_pop", '0);
    checkOutput("empty_pop_triggers", 64'(trig_count - t0), 64'(0));
`endif

    // Random request sets, ops and stack latencies.
    rand_lat = 1'b1;
    for (int n = 0; n < 15; n++) begin
      mask  = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      ops   = NREQ'($urandom);
      avail = model_stack.size();
      for (int i = 0; i < NREQ; i++) begin
        if (mask[i] && !ops[i]) begin
          if (avail > 0) avail--;
          else ops[i] = 1'b1;
        end
      end
      runBatch(mask, ops, $countones(mask), 1'b0, "rand", {$urandom, $urandom, $urandom});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
